// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg: shared FSM state type and wrap-counter width for cnt_ctrl
package cnt_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} cnt_ctrl_state_t;
  localparam int WRAPS_W = 8;
endpackage

// File: rtl/cnt_ctrl_wrap_cnt.sv
// cnt_ctrl_wrap_cnt: WRAPS_W-bit saturating event counter with sync clear
// Ports: clk, rstn (sync, active-low), clr (sync clear), inc (count enable),
//        value (current count, sticks at all-ones)
module cnt_ctrl_wrap_cnt
  import cnt_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               inc,
  output logic [WRAPS_W-1:0] value
);
  always_ff @(posedge clk)
    if (!rstn || clr) value <= '0;
    else if (inc && !(&value)) value <= value + 1'b1;
endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: job controller that presets an up/down counter and runs it to a target
// Ports: clk, rstn (sync, active-low); cmd_valid/cmd_ready handshake with
//        cmd_start, cmd_target, cmd_down; counter drive load_en, load, down;
//        counter feedback count, rollover; status busy, done, done_wraps,
//        and timeout when CNT_CTRL_TIMEOUT_EN is defined.
// Macro CNT_CTRL_TIMEOUT_EN: aborts a job after TIMEOUT RUN cycles without a match.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_start,
  input  logic [WIDTH-1:0]   cmd_target,
  input  logic               cmd_down,
  output logic               load_en,
  output logic [WIDTH-1:0]   load,
  output logic               down,
  input  logic [WIDTH-1:0]   count,
  input  logic               rollover,
  output logic               busy,
  output logic               done,
`ifdef CNT_CTRL_TIMEOUT_EN
  output logic [WRAPS_W-1:0] done_wraps,
  output logic               timeout
`else
  output logic [WRAPS_W-1:0] done_wraps
`endif
);
  cnt_ctrl_state_t  state;
  logic [WIDTH-1:0] target;
  logic             k0;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cnt_ctrl: TIMEOUT must be at least 1");
  end
`ifdef CNT_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cyc;
`endif
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  // load/down double as the latched start value and direction
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      load_en <= 1'b0;
      load    <= '0;
      down    <= 1'b0;
      done    <= 1'b0;
      target  <= '0;
      k0      <= 1'b0;
`ifdef CNT_CTRL_TIMEOUT_EN
      timeout <= 1'b0;
      cyc     <= '0;
`endif
    end else begin
      load_en <= 1'b0;
      done    <= 1'b0;
      k0      <= 1'b0;
`ifdef CNT_CTRL_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: if (cmd_valid) begin
          target  <= cmd_target;
          load    <= cmd_start;
          down    <= cmd_down;
          load_en <= 1'b1;
          state   <= LOAD;
        end
        LOAD: begin
          k0    <= 1'b1;
          state <= RUN;
`ifdef CNT_CTRL_TIMEOUT_EN
          cyc   <= '0;
`endif
        end
        RUN: begin
`ifdef CNT_CTRL_TIMEOUT_EN
          cyc <= cyc + 1'b1;
`endif
          if (count == target) begin
            done  <= 1'b1;
            state <= DONE;
          end
`ifdef CNT_CTRL_TIMEOUT_EN
          else if (cyc == TLAST) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            state   <= DONE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
  // k0 marks RUN cycle k=0, whose rollover is the preset value, not a wrap
  cnt_ctrl_wrap_cnt u_wraps (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (state == LOAD),
    .inc   (state == RUN && !k0 && rollover),
    .value (done_wraps)
  );
endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed self-checking bench for cnt_ctrl with a behavioural up/down counter
module tb_cnt_ctrl;
  localparam int W  = 4;
  localparam int TO = 8;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_target = '0;
  logic         cmd_down = 1'b0;
  logic         load_en;
  logic [W-1:0] load;
  logic         down;
  logic [W-1:0] count;
  logic         rollover;
  logic         busy;
  logic         done;
  logic [7:0]   done_wraps;
  int           total = 0;
  int           bad = 0;
`ifdef CNT_CTRL_TIMEOUT_EN
  logic         timeout;
`endif
  always #5 clk = ~clk;
  // stand-in for counter_ud: load has priority, otherwise count every cycle
  always_ff @(posedge clk)
    if (!rstn) count <= '0;
    else if (load_en) count <= load;
    else count <= down ? count - 1'b1 : count + 1'b1;
  assign rollover = &count;
  cnt_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_target (cmd_target),
    .cmd_down   (cmd_down),
    .load_en    (load_en),
    .load       (load),
    .down       (down),
    .count      (count),
    .rollover   (rollover),
    .busy       (busy),
    .done       (done),
`ifdef CNT_CTRL_TIMEOUT_EN
    .done_wraps (done_wraps),
    .timeout    (timeout)
`else
    .done_wraps (done_wraps)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one full job: handshake at E0, expect done after edge E<lat>
  task automatic job(input string tag, input logic [W-1:0] s, input logic [W-1:0] t,
                     input logic dn, input int lat, input int wraps, input logic to);
    int  n;
    logic rdy_seen;
    cmd_start  = s;
    cmd_target = t;
    cmd_down   = dn;
    cmd_valid  = 1'b1;
    tick;
    cmd_valid = 1'b0;
    chk({tag, ".load_en"}, load_en, 1);
    chk({tag, ".load"}, load, s);
    chk({tag, ".down"}, down, dn);
    n = 0;
    rdy_seen = 1'b0;
    do begin
      tick;
      n++;
      if (cmd_ready) rdy_seen = 1'b1;
    end while (!done && n < 40);
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".ready_low"}, rdy_seen, 0);
    chk({tag, ".wraps"}, done_wraps, wraps);
`ifdef CNT_CTRL_TIMEOUT_EN
    chk({tag, ".timeout"}, timeout, to);
`else
    chk({tag, ".to_unused"}, to, 0);
`endif
    tick;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".ready_back"}, cmd_ready, 1);
  endtask
  initial begin
    tick;
    tick;
    chk("rst.ready", cmd_ready, 1);
    chk("rst.load_en", load_en, 0);
    chk("rst.load", load, 0);
    chk("rst.down", down, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.wraps", done_wraps, 0);
`ifdef CNT_CTRL_TIMEOUT_EN
    chk("rst.timeout", timeout, 0);
`endif
    rstn = 1'b1;
    tick;
    job("up3_7", 4'h3, 4'h7, 1'b0, 6, 0, 1'b0);
    job("upE_1", 4'hE, 4'h1, 1'b0, 5, 1, 1'b0);
    job("dn2_D", 4'h2, 4'hD, 1'b1, 7, 1, 1'b0);
    job("upF_F", 4'hF, 4'hF, 1'b0, 2, 0, 1'b0);
`ifdef CNT_CTRL_TIMEOUT_EN
    job("tmo", 4'h0, 4'h9, 1'b0, TO + 1, 0, 1'b1);
`endif
    // held valid: job A 3->5 up (d=2), job B queued behind it
    cmd_start  = 4'h3;
    cmd_target = 4'h5;
    cmd_down   = 1'b0;
    cmd_valid  = 1'b1;
    tick;
    cmd_start  = 4'h0;
    cmd_target = 4'hA;
    chk("hold.E0_load_en", load_en, 1);
    tick;
    chk("hold.E1_load_kept", load, 3);
    chk("hold.E1_busy", busy, 1);
    tick;
    tick;
    tick;
    chk("hold.E4_done", done, 1);
    chk("hold.E4_ready", cmd_ready, 0);
    tick;
    chk("hold.E5_ready", cmd_ready, 1);
    chk("hold.E5_load_en", load_en, 0);
    tick;
    chk("hold.E6_load_en", load_en, 1);
    chk("hold.E6_load", load, 0);
    cmd_valid = 1'b0;
    tick;
    tick;
    chk("hold.E8_busy", busy, 1);
    rstn = 1'b0;
    tick;
    chk("mid_rst.ready", cmd_ready, 1);
    chk("mid_rst.load_en", load_en, 0);
    chk("mid_rst.busy", busy, 0);
    chk("mid_rst.done", done, 0);
    chk("mid_rst.load", load, 0);
    rstn = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        tick;
        if (done || busy) seen = 1'b1;
      end
      chk("mid_rst.no_done", seen, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
